button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4 (legal range 2..65535): number of consecutive stable synchronized samples required to accept a new level.
REQ-002 The block SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port i_btn  input  1  raw, asynchronous, bouncing button/switch level.
REQ-005 The block SHALL have port o_level  output  1  debounced level; directly drives a downstream flip-flop data input.
REQ-006 The block SHALL have port o_rise  output  1  one-cycle pulse on an accepted 0->1 transition.
REQ-007 The block SHALL have port o_fall  output  1  one-cycle pulse on an accepted 1->0 transition.

Function
REQ-008 i_btn SHALL pass through a two-stage synchronizer (ff1, ff2) before any other use; the ff2 output is called s.
REQ-009 The FSM SHALL have exactly four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-010 LOW: if s=1 -> WAIT_HIGH with counter cleared to 0; otherwise stay.
REQ-011 WAIT_HIGH: if s=0 -> LOW (bounce rejected, no pulse); else if counter = STABLE_CYCLES-1 -> HIGH; else counter increments by 1.
REQ-012 HIGH: if s=0 -> WAIT_LOW with counter cleared to 0; otherwise stay.
REQ-013 WAIT_LOW: if s=1 -> HIGH (bounce rejected, no pulse); else if counter = STABLE_CYCLES-1 -> LOW; else counter increments by 1.
REQ-014 The counter width SHALL be $clog2(STABLE_CYCLES), and the counter SHALL never wrap; it is only compared against STABLE_CYCLES-1.
REQ-015 All outputs SHALL be registered; o_level SHALL be 1 exactly in states HIGH and WAIT_LOW.
REQ-016 o_rise SHALL be 1 for exactly the one cycle following the WAIT_HIGH->HIGH edge; o_fall likewise for WAIT_LOW->LOW.
REQ-017 o_rise and o_fall SHALL never be 1 in the same cycle, and each pulse SHALL coincide with the cycle in which o_level first shows the new value.
REQ-018 Latency: if i_btn changes before edge 1 and stays stable, o_level SHALL change after edge STABLE_CYCLES+3 (edge 7 at default), and not earlier.
REQ-019 A pulse on s shorter than STABLE_CYCLES cycles SHALL produce no change on o_level, o_rise or o_fall.
REQ-020 Continuous toggling of i_btn at any rate SHALL keep o_level at its last accepted value.

Reset
REQ-021 While i_rst=1, ff1, ff2, the counter and all outputs SHALL be 0 and the FSM SHALL be in LOW, independent of i_clk.
REQ-022 Assertion of i_rst mid-WAIT_HIGH or mid-WAIT_LOW SHALL abort the qualification immediately, producing no pulse.
REQ-023 After reset release with i_btn=1 held, the block SHALL qualify it as a normal rise (o_rise pulses once, per REQ-018 timing).

Structure
REQ-024 Package debounce_pkg SHALL hold the state enum typedef (LOW, WAIT_HIGH, HIGH, WAIT_LOW) and the constant DEFAULT_STABLE_CYCLES = 4.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (ports i_clk, i_rst, i_d, o_q), instantiated once.
REQ-026 The FSM and counter SHALL live in button_debouncer; no combinational path from i_btn to any output is permitted.

Verification (clock period 10, STABLE_CYCLES=4, i_btn changes 2 time units after a rising edge)
REQ-027 Reset: i_rst=1 with i_btn=1 for 3 cycles -> o_level=0, o_rise=0, o_fall=0 throughout, including before the first clock edge.
REQ-028 Clean press: i_btn 0->1 and held -> o_level=0 through edge 6, o_level=1 and o_rise=1 after edge 7, o_rise=0 after edge 8.
REQ-029 Bounce: i_btn high for 2 cycles, low for 1, high for 3, then low -> o_level stays 0, no pulses.
REQ-030 Clean release from HIGH: i_btn 1->0 and held -> o_level=0 and o_fall=1 after 7th edge, o_fall=0 one cycle later, o_rise=0 throughout.
REQ-031 Reset mid-qualification: press, assert i_rst after edge 5 for 1 cycle, release reset with i_btn=1 -> no pulse during reset, then o_rise=1 exactly once, 7 edges after release.
REQ-032 Chain check: o_level drives d_flip_flop.i_d -> its o_q follows o_level one cycle later and o_qn is its complement.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debouncer:
//   - DEFAULT_STABLE_CYCLES : default qualification length in synchronized samples
//   - state_e               : debouncer FSM state encoding
//   - state_level           : debounced level associated with a state
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 4;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    // The output keeps showing the accepted level while a change is only
    // being qualified, so WAIT_LOW still reports 1 and WAIT_HIGH still 0.
    function automatic logic state_level(input state_e st);
        return (st == HIGH) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/d_flip_flop.sv
// -----------------------------------------------------------------------------
// d_flip_flop
// Plain D flip-flop used downstream of the debouncer's o_level output.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset, clears o_q
//   i_d   : data input
//   o_q   : registered data
//   o_qn  : complement of o_q
// -----------------------------------------------------------------------------
module d_flip_flop (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_qn
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = i_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q  = q_q;
    assign o_qn = ~q_q;

endmodule

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-stage synchronizer bringing an asynchronous level into the i_clk domain.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset, clears both stages
//   i_d   : asynchronous input level
//   o_q   : synchronized level (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic ff1_q;
    logic ff1_d;
    logic ff2_q;
    logic ff2_d;

    always_comb begin
        ff1_d = i_d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign o_q = ff2_q;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Debounces a raw mechanical button level. The input is synchronized, then a
// four-state FSM accepts a new level only after STABLE_CYCLES+1 consecutive
// synchronized samples agree (the entry sample plus STABLE_CYCLES counted ones).
// Parameters:
//   STABLE_CYCLES : qualification length, legal range 2..65535
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_btn   : raw asynchronous button level
//   o_level : registered debounced level
//   o_rise  : registered one-cycle pulse on an accepted 0->1 change
//   o_fall  : registered one-cycle pulse on an accepted 1->0 change
// -----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic s;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_btn),
        .o_q   (s)
    );

    // Next-state and counter logic. The counter stops at CNT_LAST because the
    // state leaves the WAIT_* state on that same sample, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that the pulse and the
    // new level appear together, in the cycle right after the accepting edge.
    always_comb begin
        level_d = state_level(state_d);
        rise_d  = (state_q == WAIT_HIGH) && (state_d == HIGH);
        fall_d  = (state_q == WAIT_LOW)  && (state_d == LOW);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Self-checking bench for button_debouncer with a downstream d_flip_flop.
// A run-length model predicts the outputs every cycle; directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int SC = 4;

    logic clk;
    logic rst;
    logic btn;
    logic o_level;
    logic o_rise;
    logic o_fall;
    logic ff_q;
    logic ff_qn;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    button_debouncer #(.STABLE_CYCLES(SC)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (btn),
        .o_level (o_level),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    d_flip_flop u_chain (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (o_level),
        .o_q   (ff_q),
        .o_qn  (ff_qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0b required=%0b", name, $time, act, exp);
        end
    endtask

    // Model: the raw level is seen two edges late; a new level is accepted once
    // SC+1 consecutive delayed samples disagree with the accepted level.
    logic m_s1, m_s2, m_level, m_rise, m_fall, m_chain;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_level <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_chain <= 1'b0;
            m_run   <= 0;
        end else begin
            m_s1    <= btn;
            m_s2    <= m_s1;
            m_chain <= m_level;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            if (m_s2 != m_level) begin
                if (m_run + 1 == SC + 1) begin
                    m_level <= m_s2;
                    m_rise  <= m_s2;
                    m_fall  <= ~m_s2;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_level", o_level, m_level);
            check("model_rise",  o_rise,  m_rise);
            check("model_fall",  o_fall,  m_fall);
            check("rise_fall_exclusive", o_rise & o_fall, 1'b0);
            check("chain_q",  ff_q,  m_chain);
            check("chain_qn", ff_qn, ~m_chain);
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    task automatic show(input string what);
        $display("%s t=%0t btn=%0b level=%0b rise=%0b fall=%0b q=%0b", what, $time, btn, o_level, o_rise, o_fall, ff_q);
    endtask

    int holds [10] = '{3, 5, 4, 6, 1, 7, 2, 8, 5, 9};

    initial begin
        // Reset held with the button pressed, checked before any clock edge.
        rst = 1'b1;
        btn = 1'b1;
        #1;
        check("reset_pre_edge_level", o_level, 1'b0);
        check("reset_pre_edge_rise",  o_rise,  1'b0);
        check("reset_pre_edge_fall",  o_fall,  1'b0);
        cmp_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            edge_step();
            check("reset_level", o_level, 1'b0);
            check("reset_rise",  o_rise,  1'b0);
            check("reset_fall",  o_fall,  1'b0);
            show("reset");
        end
        rst = 1'b0;
        btn = 1'b0;
        repeat (6) edge_step();

        // Clean press.
        btn = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            edge_step();
            check("press_early_level", o_level, 1'b0);
            check("press_early_rise",  o_rise,  1'b0);
        end
        edge_step();
        check("press_e7_level", o_level, 1'b1);
        check("press_e7_rise",  o_rise,  1'b1);
        check("press_e7_chain", ff_q,    1'b0);
        show("press_e7");
        edge_step();
        check("press_e8_rise",  o_rise,  1'b0);
        check("press_e8_level", o_level, 1'b1);
        check("press_e8_chain", ff_q,    1'b1);
        check("press_e8_chainn", ff_qn,  1'b0);
        show("press_e8");
        repeat (3) edge_step();

        // Clean release.
        btn = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            edge_step();
            check("release_early_level", o_level, 1'b1);
            check("release_early_fall",  o_fall,  1'b0);
            check("release_rise",        o_rise,  1'b0);
        end
        edge_step();
        check("release_e7_level", o_level, 1'b0);
        check("release_e7_fall",  o_fall,  1'b1);
        check("release_e7_rise",  o_rise,  1'b0);
        show("release_e7");
        edge_step();
        check("release_e8_fall", o_fall, 1'b0);
        show("release_e8");
        repeat (3) edge_step();

        // Bounce: high 2, low 1, high 3, then low.
        btn = 1'b1; edge_step(); edge_step();
        btn = 1'b0; edge_step();
        btn = 1'b1; edge_step(); edge_step(); edge_step();
        btn = 1'b0;
        for (int n = 0; n < 10; n++) begin
            edge_step();
            check("bounce_level", o_level, 1'b0);
            check("bounce_rise",  o_rise,  1'b0);
            check("bounce_fall",  o_fall,  1'b0);
        end
        show("bounce");

        // Toggling at several rates while low keeps the level low.
        for (int rate = 1; rate <= SC; rate++) begin
            for (int n = 0; n < 16; n++) begin
                if (n % rate == 0) btn = ~btn;
                edge_step();
                check("toggle_low_level", o_level, 1'b0);
            end
        end
        show("toggle_low");
        btn = 1'b1;
        repeat (10) edge_step();
        check("settle_high_level", o_level, 1'b1);
        // Same while high.
        for (int rate = 1; rate <= SC; rate++) begin
            for (int n = 0; n < 16; n++) begin
                if (n % rate == 0) btn = ~btn;
                edge_step();
                check("toggle_high_level", o_level, 1'b1);
            end
        end
        show("toggle_high");

        // Mixed hold lengths around the threshold; the model checks each cycle.
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (holds[i]) edge_step();
            show("hold");
        end

        // Reset in the middle of a rising qualification, released with btn=1.
        btn = 1'b0;
        repeat (12) edge_step();
        btn = 1'b1;
        repeat (5) edge_step();
        rst = 1'b1;
        #1;
        check("midrst_rise",  o_rise,  1'b0);
        check("midrst_level", o_level, 1'b0);
        edge_step();
        check("midrst_held_rise", o_rise, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            edge_step();
            check("midrst_early_rise",  o_rise,  1'b0);
            check("midrst_early_level", o_level, 1'b0);
        end
        edge_step();
        check("midrst_e7_rise",  o_rise,  1'b1);
        check("midrst_e7_level", o_level, 1'b1);
        show("midrst_e7");
        edge_step();
        check("midrst_e8_rise", o_rise, 1'b0);

        // Reset in the middle of a falling qualification, released with btn=0.
        btn = 1'b0;
        repeat (4) edge_step();
        rst = 1'b1;
        edge_step();
        check("midrst_low_fall", o_fall, 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            edge_step();
            check("midrst_low_fall_after", o_fall,  1'b0);
            check("midrst_low_level",      o_level, 1'b0);
        end
        show("midrst_low");

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
